// File: rtl/bus_rcv_fifo.sv
// Bus receiver: synchronizes STB_N, acknowledges with a four-phase ACK_N handshake and buffers words in a FIFO.
// Optional odd-parity checking is enabled by defining BUS_RCV_FIFO_PARITY_EN.
module bus_rcv_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic [WIDTH-1:0]         BUS_IN,
   input  logic                     BUS_PAR,
   input  logic                     STB_N,
   output logic                     ACK_N,
   output logic [WIDTH-1:0]         OUT_DATA,
   output logic                     OUT_VALID,
   input  logic                     OUT_RD,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     FULL,
   output logic                     PAR_ERR,
   input  logic                     ERR_CLR
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   stb_s;
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic                   ack_n_r;
   logic                   ack_n_nxt_s;
   logic                   wr_en_s;
   logic                   rd_en_s;
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [CW-1:0]          count_r;
   logic [CW-1:0]          count_nxt_s;
   logic                   full_r;
   logic                   valid_r;
   logic                   par_err_r;
   logic                   par_err_nxt_s;
   logic [WIDTH-1:0]       mem_r [DEPTH];

`ifdef BUS_RCV_FIFO_PARITY_EN
   // Odd parity holds when the XOR over parity bit and data is 1.
   function automatic logic odd_parity_ok(input logic [WIDTH:0] word);
      return ^word;
   endfunction
`endif

   assign stb_s     = ~sync_r[SYNC_STAGES-1];
   assign rd_en_s   = OUT_RD & valid_r;
   assign ACK_N     = ack_n_r;
   assign COUNT     = count_r;
   assign FULL      = full_r;
   assign OUT_VALID = valid_r;
   assign PAR_ERR   = par_err_r;
   assign OUT_DATA  = mem_r[rd_ptr_r];

   // Handshake FSM: one capture per strobe, gated by the registered full flag.
   always_comb begin
      state_nxt_s = state_r;
      ack_n_nxt_s = ack_n_r;
      wr_en_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (stb_s && !full_r) begin
               wr_en_s     = 1'b1;
               ack_n_nxt_s = 1'b0;
               state_nxt_s = ST_HOLD;
            end else begin
               ack_n_nxt_s = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!stb_s) begin
               ack_n_nxt_s = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               ack_n_nxt_s = 1'b0;
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            ack_n_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Occupancy update; a simultaneous write and read leaves the count unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Sticky parity error; a failing capture wins over a simultaneous clear.
   always_comb begin
      par_err_nxt_s = par_err_r;
`ifdef BUS_RCV_FIFO_PARITY_EN
      if (wr_en_s && !odd_parity_ok({BUS_PAR, BUS_IN})) begin
         par_err_nxt_s = 1'b1;
      end else if (ERR_CLR) begin
         par_err_nxt_s = 1'b0;
      end else begin
         par_err_nxt_s = par_err_r;
      end
`else
      par_err_nxt_s = 1'b0;
`endif
   end

`ifndef BUS_RCV_FIFO_PARITY_EN
   logic unused_s;
   assign unused_s = BUS_PAR ^ ERR_CLR;
`endif

   // Control state: synchronizer, FSM, pointers and status flags.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sync_r    <= {SYNC_STAGES{1'b1}};
         state_r   <= ST_IDLE;
         ack_n_r   <= 1'b1;
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         full_r    <= 1'b0;
         valid_r   <= 1'b0;
         par_err_r <= 1'b0;
      end else begin
         sync_r    <= {sync_r[SYNC_STAGES-2:0], STB_N};
         state_r   <= state_nxt_s;
         ack_n_r   <= ack_n_nxt_s;
         count_r   <= count_nxt_s;
         full_r    <= (count_nxt_s == CW'(DEPTH));
         valid_r   <= (count_nxt_s != {CW{1'b0}});
         par_err_r <= par_err_nxt_s;
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Storage array; contents after reset are don't-care so it carries no reset.
   always_ff @(posedge CLK) begin
      if (RESET_N && wr_en_s) begin
         mem_r[wr_ptr_r] <= BUS_IN;
      end
   end

endmodule
